// File: rtl/rollo_pkg.sv
// Shared constants for the ROLLO register file: command opcodes, controller
// state codes and the chunk-count helper.
package rollo_pkg;

   localparam int DEF_M     = 67;
   localparam int DEF_R     = 7;
   localparam int DEF_LANES = 2;

   localparam logic [1:0] OP_WRITE   = 2'b00;
   localparam logic [1:0] OP_READ    = 2'b01;
   localparam logic [1:0] OP_COMBINE = 2'b10;
   localparam logic [1:0] OP_CLEAR   = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_ACC  = 2'b01;
   localparam logic [1:0] ST_RSP  = 2'b10;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/rollo_lincomb_lane.sv
// Masked XOR of LANES words: each word joins the fold only when its select
// bit is set.
module rollo_lincomb_lane
   import rollo_pkg::*;
#(
   parameter int M     = DEF_M,
   parameter int LANES = DEF_LANES
) (
   input  logic [LANES-1:0][M-1:0] i_words,
   input  logic [LANES-1:0]        i_sel,
   output logic [M-1:0]            o_xor
);

   always_comb begin
      // NOTE: blocking assignments here build a combinational XOR chain; the
      // default keeps the output fully assigned so no latch is inferred.
      o_xor = '0;
      for (int j = 0; j < LANES; j++) begin
         if (i_sel[j]) o_xor = o_xor ^ i_words[j];
      end
   end

endmodule

// File: rtl/rollo_regfile_lincomb.sv
// GF(2)-vector register file with write/read/clear and a multi-cycle
// coefficient-selected XOR combination returned over a valid/ready port.
module rollo_regfile_lincomb
   import rollo_pkg::*;
#(
   parameter  int M     = DEF_M,
   parameter  int R     = DEF_R,
   parameter  int LANES = DEF_LANES,
   localparam int AW    = $clog2(R)
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [1:0]    cmd_op,
   input  logic [AW-1:0] cmd_addr,
   input  logic [M-1:0]  cmd_data,
   input  logic [R-1:0]  cmd_coef,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [M-1:0]  rsp_data,
   output logic          rsp_err
);

   localparam int C  = ceil_div(R, LANES);
   localparam int CW = (C > 1) ? $clog2(C) : 1;
   localparam int NP = C * LANES;
   localparam int KW = $clog2(NP);
   localparam logic [AW:0]   R_LIM      = (AW+1)'(R);
   localparam logic [CW-1:0] LAST_CHUNK = CW'(C - 1);

   (* srl_style = "register" *) logic [M-1:0] r_entry [R];

   logic [1:0]    r_state;
   logic [CW-1:0] r_chunk;
   logic [R-1:0]  r_coef;
   logic [M-1:0]  r_acc;
   logic          r_err;
   logic          r_rsp_valid;
   logic [M-1:0]  r_rsp_data;
   logic          r_rsp_err;

   logic                   w_accept;
   logic                   w_addr_ok;
   logic [M-1:0]           w_rd_word;
   logic [M-1:0]           w_pad_word [NP];
   logic [NP-1:0]          w_pad_coef;
   logic [LANES-1:0][M-1:0] w_lane_word;
   logic [LANES-1:0]       w_lane_sel;
   logic [M-1:0]           w_lane_xor;

   assign cmd_ready = (r_state == ST_IDLE) & ~r_rsp_valid;
   assign w_accept  = cmd_valid & cmd_ready;
   assign w_addr_ok = {1'b0, cmd_addr} < R_LIM;
   assign w_rd_word = w_addr_ok ? r_entry[cmd_addr] : '0;

   // Pad the entry set up to a whole number of chunks so lanes past R read 0.
   for (genvar k = 0; k < NP; k++) begin : g_pad
      if (k < R) begin : g_live
         assign w_pad_word[k] = r_entry[k];
      end else begin : g_zero
         assign w_pad_word[k] = '0;
      end
   end
   assign w_pad_coef = NP'(r_coef);

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [KW-1:0] w_idx;
      assign w_idx          = KW'(r_chunk) * KW'(LANES) + KW'(j);
      assign w_lane_word[j] = w_pad_word[w_idx];
      assign w_lane_sel[j]  = w_pad_coef[w_idx];
   end

   rollo_lincomb_lane #(
      .M     (M),
      .LANES (LANES)
   ) u_lane (
      .i_words (w_lane_word),
      .i_sel   (w_lane_sel),
      .o_xor   (w_lane_xor)
   );

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         // NOTE: the entry array is reset on purpose so every word reads 0
         // after reset; this keeps it in flops rather than RAM/SRL cells.
         for (int i = 0; i < R; i++) r_entry[i] <= '0;
      end else if (w_accept) begin
         if (cmd_op == OP_CLEAR) begin
            for (int i = 0; i < R; i++) r_entry[i] <= '0;
         end else if ((cmd_op == OP_WRITE) && w_addr_ok) begin
            r_entry[cmd_addr] <= cmd_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         // NOTE: sequential state uses non-blocking assignments only.
         r_state     <= ST_IDLE;
         r_chunk     <= '0;
         r_coef      <= '0;
         r_acc       <= '0;
         r_err       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (cmd_op)
                     OP_READ: begin
                        r_acc   <= w_rd_word;
                        r_err   <= ~w_addr_ok;
                        r_state <= ST_RSP;
                     end
                     OP_COMBINE: begin
                        r_coef  <= cmd_coef;
                        r_acc   <= '0;
                        r_chunk <= '0;
                        r_err   <= 1'b0;
                        r_state <= ST_ACC;
                     end
                     default: ;
                  endcase
               end
            end
            ST_ACC: begin
               r_acc <= r_acc ^ w_lane_xor;
               if (r_chunk == LAST_CHUNK) begin
                  r_chunk <= '0;
                  r_state <= ST_RSP;
               end else begin
                  r_chunk <= r_chunk + CW'(1);
               end
            end
            ST_RSP: begin
               // First RSP cycle publishes the result; it is then frozen until taken.
               if (!r_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= r_acc;
                  r_rsp_err   <= r_err;
               end else if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign rsp_err   = r_rsp_err;

endmodule

// File: doc/rollo_regfile_lincomb.md
# rollo_regfile_lincomb

Parametrised GF(2)-vector register file for the ROLLO encrypt datapath. Holds R words of M bits and serves writes, reads, bulk clear, and coefficient-selected XOR combinations of its entries. A combination is computed over several cycles, LANES entries per cycle, and returned through a valid/ready response port. It sits between the support-generation logic (writer) and the syndrome/ciphertext datapath (consumer of combinations).

## Interface
- M, default 67: entry width in bits (GF(2^M) element).
- R, default 7: number of entries, any value ≥ 2, not necessarily a power of two.
- LANES, default 2: entries folded per accumulate cycle, 1..R; C = ceil(R/LANES) accumulate cycles.
- AW, derived `CLOG2(R)`: address width.

- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when valid&ready.
- cmd_op  in  2  00 WRITE, 01 READ, 10 COMBINE, 11 CLEAR.
- cmd_addr  in  AW  entry index for WRITE and READ.
- cmd_data  in  M  write data.
- cmd_coef  in  R  COMBINE coefficients; bit i selects entry i.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when valid&ready.
- rsp_data  out  M  read word or combination result.
- rsp_err  out  1  qualifies rsp_data: READ to address ≥ R.

## Operation
- States: IDLE, ACC, RSP.
- cmd_ready = (state == IDLE) & ~rsp_valid; no command is accepted while a response is pending or a combination is running.
- WRITE, addr < R: entry[addr] ← cmd_data. Address ≥ R: ignored silently. No response.
- CLEAR: all entries ← 0 in one cycle. No response.
- READ: rsp_data ← entry[addr], rsp_err ← 0; address ≥ R gives rsp_data = 0, rsp_err = 1. Goes to RSP.
- COMBINE on accept:
  - latch cmd_coef into coef_q;
  - acc ← 0, chunk ← 0;
  - go to ACC.
- ACC, per cycle:
  - acc ^= XOR over j in 0..LANES-1 of (coef_q[k] ? entry[k] : 0), with k = chunk·LANES + j;
  - terms with k ≥ R contribute 0;
  - chunk increments each cycle.
- After chunk C-1 completes: rsp_data ← final acc, rsp_err ← 0, go to RSP.
- Latency is fixed at C cycles regardless of coefficient value. All-zero coef returns 0.
- RSP: hold rsp_valid, rsp_data, and rsp_err stable until rsp_ready; on handshake return to IDLE.
- Entries cannot change during ACC, because no command is accepted then. The result is therefore a consistent snapshot.

## Timing
- Reset (async assert, sync release):
  - all entries = 0;
  - rsp_valid = 0, rsp_data = 0, rsp_err = 0;
  - state = IDLE, chunk = 0, acc = 0;
  - cmd_ready = 1 from the first cycle after release.
- Reset mid-ACC or mid-RSP aborts the operation. No response is produced.
- WRITE accepted at edge t: visible to a READ accepted at edge t+1.
- READ accepted at edge t: rsp_valid high after edge t+1.
- COMBINE accepted at edge t: rsp_valid high after edge t+C+1. With defaults C = 4.
- rsp_ready held high: the next command is accepted at the response-handshake edge + 1 cycle, because cmd_ready rises after rsp_valid falls.
- rsp_ready low: the response is held indefinitely with no loss.

## Structure
- Shared package rollo_pkg:
  - op encodings: OP_WRITE, OP_READ, OP_COMBINE, OP_CLEAR;
  - state encoding;
  - ceil-divide constant function for C.
- Use `CLOG2` from clog2.v and defaults from define.v (`M`, `R`).
- One sub-module, rollo_lincomb_lane:
  - combinational masked XOR of LANES M-bit words;
  - inputs: LANES words and LANES select bits;
  - instantiated once, fed by a chunk-indexed multiplexer.
- Entry storage is a register array; the srl_style register attribute is kept.

## Test plan
All scenarios use M=67, R=7, LANES=2.
- Reset then READ addr 3 → rsp_data 0, rsp_err 0, one cycle after accept.
- WRITE entry i = i+1 (i = 0..6), then COMBINE coef 7'b1010101 (entries 0,2,4,6) → rsp_data = 1^3^5^7 = 0x0, rsp_err 0, exactly 5 cycles after accept.
- Same contents, COMBINE coef 7'b1111111 → 1^2^3^4^5^6^7 = 0x0. COMBINE coef 7'b0000011 → 0x3. Each takes 5 cycles.
- READ addr 7 (out of range) → rsp_data 0, rsp_err 1. A WRITE to addr 7 leaves all entries unchanged, checked by reading back 0..6.
- COMBINE with rsp_ready low for 10 cycles → rsp_data held stable, cmd_ready stays 0. Commands presented meanwhile are not accepted. On rsp_ready the handshake completes and the next command is accepted one cycle later.
- Assert rst_b low during the third ACC cycle → outputs 0 immediately and no response appears. After release a READ of any entry returns 0. CLEAR after writes also yields 0 on all reads.
